// File: rtl/lrhls_top_sdiv_34s_16ns_18.sv
// Sequential divider: 34-bit signed dividend / 16-bit unsigned divisor -> 18-bit saturated signed quotient + remainder.
// Latency: ap_start accepted in cycle N gives ap_done in cycle N+36; one operation per 37 cycles.
// Backpressure: none; ap_start is ignored unless idle. Define LRHLS_DIV_ROUND_EN for round-half-away-from-zero.
module lrhls_top_sdiv_34s_16ns_18 #(
    parameter int ID         = 1,
    parameter int din0_WIDTH = 34,
    parameter int din1_WIDTH = 16,
    parameter int dout_WIDTH = 18
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  ap_start,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  ap_ready,
    output logic                  ap_idle,
    output logic                  ap_done,
    output logic [dout_WIDTH-1:0] dout,
    output logic [din1_WIDTH-1:0] rem,
    output logic                  ovf,
    output logic                  div0
);

    localparam int QW = din0_WIDTH;
    localparam int RW = din1_WIDTH;
    localparam int OW = dout_WIDTH;
    localparam int CW = $clog2(QW);

    // Largest negative quotient magnitude and largest positive quotient, in magnitude-register width.
    localparam logic [QW:0]   NEG_MAG  = (QW + 1)'(1) << (OW - 1);
    localparam logic [QW:0]   POS_MAX  = NEG_MAG - (QW + 1)'(1);
    localparam logic [OW-1:0] OUT_POS  = {1'b0, {(OW - 1){1'b1}}};
    localparam logic [OW-1:0] OUT_NEG  = {1'b1, {(OW - 1){1'b0}}};
    localparam logic [CW-1:0] LAST_CNT = CW'(QW - 1);

    // ID only tags the instance; it has no effect on the hardware.
    if (ID < 0) begin : g_id_tag
    end

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [QW-1:0] mag_q, mag_d;      // dividend magnitude, becomes the quotient magnitude
    logic [RW-1:0] prem_q, prem_d;    // partial remainder
    logic [RW-1:0] div_q, div_d;
    logic          sign_q, sign_d;    // dividend sign; the divisor is unsigned
    logic [OW-1:0] dout_q, dout_d;
    logic [RW-1:0] rem_q, rem_d;
    logic          ovf_q, ovf_d;
    logic          div0_q, div0_d;

    logic [RW:0]   trial;
    logic          qbit;
    logic [QW:0]   qmag;              // one extra bit so rounding up cannot wrap
    logic [RW-1:0] rmag;
    logic [OW-1:0] qtrunc;

    // One restoring step: bring in the next dividend bit and try to subtract the divisor.
    always_comb begin
        trial  = {prem_q, mag_q[QW-1]};
        qbit   = (trial >= {1'b0, div_q});
        qtrunc = sign_q ? -qmag[OW-1:0] : qmag[OW-1:0];
    end

`ifdef LRHLS_DIV_ROUND_EN
    logic rnd;
    // Round half away from zero in the magnitude domain; the sign is applied afterwards.
    always_comb begin
        rnd  = (div_q != '0) && ({prem_q, 1'b0} >= {1'b0, div_q});
        qmag = {1'b0, mag_q} + (QW + 1)'(rnd);
        rmag = rnd ? (prem_q - div_q) : prem_q;
    end
`else
    // Truncation toward zero: the magnitudes pass straight through.
    always_comb begin
        qmag = {1'b0, mag_q};
        rmag = prem_q;
    end
`endif

    // Control: next state and handshake outputs.
    always_comb begin
        state_d  = state_q;
        ap_idle  = 1'b0;
        ap_ready = 1'b0;
        ap_done  = 1'b0;
        case (state_q)
            S_IDLE: begin
                ap_idle  = 1'b1;
                ap_ready = ap_start && ap_rst_n;
                if (ap_start) state_d = S_CALC;
            end
            S_CALC:  if (cnt_q == LAST_CNT) state_d = S_FIX;
            S_FIX:   state_d = S_DONE;
            S_DONE: begin
                ap_done = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next state: capture, shift-subtract, then sign/saturate into the result registers.
    always_comb begin
        cnt_d  = cnt_q;
        mag_d  = mag_q;
        prem_d = prem_q;
        div_d  = div_q;
        sign_d = sign_q;
        dout_d = dout_q;
        rem_d  = rem_q;
        ovf_d  = ovf_q;
        div0_d = div0_q;
        case (state_q)
            S_IDLE: begin
                if (ap_start) begin
                    sign_d = din0[QW-1];
                    mag_d  = din0[QW-1] ? -din0 : din0;   // -2^33 maps to 2^33, still fits unsigned
                    div_d  = din1;
                    prem_d = '0;
                    cnt_d  = '0;
                end
            end
            S_CALC: begin
                prem_d = qbit ? (trial[RW-1:0] - div_q) : trial[RW-1:0];
                mag_d  = {mag_q[QW-2:0], qbit};
                cnt_d  = cnt_q + CW'(1);
            end
            S_FIX: begin
                div0_d = (div_q == '0);
                ovf_d  = 1'b0;
                dout_d = qtrunc;
                rem_d  = sign_q ? -rmag : rmag;
                if (div_q == '0) begin
                    dout_d = sign_q ? OUT_NEG : OUT_POS;
                    rem_d  = '0;
                end else if (!sign_q && (qmag > POS_MAX)) begin
                    dout_d = OUT_POS;
                    ovf_d  = 1'b1;
                end else if (sign_q && (qmag > NEG_MAG)) begin
                    dout_d = OUT_NEG;
                    ovf_d  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            mag_q   <= '0;
            prem_q  <= '0;
            div_q   <= '0;
            sign_q  <= 1'b0;
            dout_q  <= '0;
            rem_q   <= '0;
            ovf_q   <= 1'b0;
            div0_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mag_q   <= mag_d;
            prem_q  <= prem_d;
            div_q   <= div_d;
            sign_q  <= sign_d;
            dout_q  <= dout_d;
            rem_q   <= rem_d;
            ovf_q   <= ovf_d;
            div0_q  <= div0_d;
        end
    end

    assign dout = dout_q;
    assign rem  = rem_q;
    assign ovf  = ovf_q;
    assign div0 = div0_q;

endmodule
